wbu_sb: RTL

WBU_SB -- requirements
Module: wbu_sb

---
 rtl/wbu_sb.sv | 137 +++++++++++++
 1 files changed

// File: rtl/wbu_sb.sv
// rtl/wbu_sb.sv - write-back unit with load extension and RAW scoreboard
module wbu_sb (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_wen,
    input  logic        in_is_load,
    input  logic [2:0]  in_ld_type,
    input  logic [31:0] in_alu_res,
    input  logic        lsu_rvalid,
    input  logic [31:0] lsu_rdata,
    input  logic        iss_fire,
    input  logic [4:0]  iss_rs1,
    input  logic [4:0]  iss_rs2,
    input  logic [4:0]  iss_rd,
    input  logic        iss_wen,
    output logic        hazard,
    output logic [4:0]  rd,
    output logic [31:0] rd_value,
    output logic        wen
);

    typedef enum logic [1:0] {IDLE, WAIT_LD, WB} state_t;

    state_t      state_q, state_d;
    logic [4:0]  lat_rd_q, lat_rd_d;
    logic        lat_wen_q, lat_wen_d;
    logic [2:0]  lat_ld_type_q, lat_ld_type_d;
    logic [1:0]  lat_addr_lo_q, lat_addr_lo_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] rd_value_q, rd_value_d;
    logic        wen_q, wen_d;
    logic [31:0] busy_q, busy_d;
    logic        hs;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    function automatic logic [31:0] load_ext(input logic [2:0] t, input logic [1:0] lo,
                                             input logic [31:0] w);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> {lo, 3'b000};
        b  = sh[7:0];
        h  = lo[1] ? w[31:16] : w[15:0];
        case (t)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'h0, b};
            3'b101:  load_ext = {16'h0, h};
            default: load_ext = w;
        endcase
    endfunction

    assign in_ready = (state_q != WAIT_LD);
    assign hs       = in_valid & in_ready;

    always_comb begin
        state_d       = state_q;
        lat_rd_d      = lat_rd_q;
        lat_wen_d     = lat_wen_q;
        lat_ld_type_d = lat_ld_type_q;
        lat_addr_lo_d = lat_addr_lo_q;
        rd_d          = rd_q;
        rd_value_d    = rd_value_q;
        wen_d         = 1'b0;
        case (state_q)
            WAIT_LD: begin
                if (lsu_rvalid) begin
                    state_d    = WB;
                    rd_d       = lat_rd_q;
                    rd_value_d = load_ext(lat_ld_type_q, lat_addr_lo_q, lsu_rdata);
                    wen_d      = lat_wen_q & (lat_rd_q != 5'd0);
                end
            end
            default: begin
                state_d = IDLE;
                if (hs) begin
                    lat_rd_d      = in_rd;
                    lat_wen_d     = in_wen;
                    lat_ld_type_d = in_ld_type;
                    lat_addr_lo_d = in_alu_res[1:0];
                    if (in_is_load) begin
                        state_d = WAIT_LD;
                    end else begin
                        // ALU results go straight to the output registers so the write lands next cycle
                        state_d    = WB;
                        rd_d       = in_rd;
                        rd_value_d = in_alu_res;
                        wen_d      = in_wen & (in_rd != 5'd0);
                    end
                end
            end
        endcase
    end

    always_comb begin
        set_mask = 32'h0;
        clr_mask = 32'h0;
        if (iss_fire && iss_wen && (iss_rd != 5'd0)) set_mask = 32'd1 << iss_rd;
        if (wen_q) clr_mask = 32'd1 << rd_q;
        // set is applied after clear so a re-issue of the retiring register stays busy
        busy_d = ((busy_q & ~clr_mask) | set_mask) & ~32'h1;
    end

    assign hazard   = busy_q[iss_rs1] | busy_q[iss_rs2] | (busy_q[iss_rd] & iss_wen);
    assign rd       = rd_q;
    assign rd_value = rd_value_q;
    assign wen      = wen_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            lat_rd_q      <= 5'd0;
            lat_wen_q     <= 1'b0;
            lat_ld_type_q <= 3'd0;
            lat_addr_lo_q <= 2'd0;
            rd_q          <= 5'd0;
            rd_value_q    <= 32'h0;
            wen_q         <= 1'b0;
            busy_q        <= 32'h0;
        end else begin
            state_q       <= state_d;
            lat_rd_q      <= lat_rd_d;
            lat_wen_q     <= lat_wen_d;
            lat_ld_type_q <= lat_ld_type_d;
            lat_addr_lo_q <= lat_addr_lo_d;
            rd_q          <= rd_d;
            rd_value_q    <= rd_value_d;
            wen_q         <= wen_d;
            busy_q        <= busy_d;
        end
    end

endmodule
